// File: rtl/multi_channel_edge_sync.sv
// N-channel synchronizer with glitch filter, qualified edge pulses and a sticky
// pending/ack event handshake with overrun detection, all in the outclk domain.
module multi_channel_edge_sync #(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int EDGE_MODE   = 0,
    parameter int RESET_LEVEL = 0
) (
    input  logic            outclk,
    input  logic            reset_n,
    input  logic [N_CH-1:0] async_in,
    input  logic [N_CH-1:0] evt_ack,
    input  logic            ovr_clr,
    output logic [N_CH-1:0] sync_level,
    output logic [N_CH-1:0] edge_pulse,
    output logic [N_CH-1:0] evt_pending,
    output logic [N_CH-1:0] evt_overrun
);

    localparam int   CW       = $clog2(FILTER_LEN + 1);
    localparam logic RST_LVL  = (RESET_LEVEL != 0);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_reg;
            logic [CW-1:0]          cnt_reg;
            logic                   level_reg;
            logic                   pulse_reg;
            logic                   pend_reg;
            logic                   ovr_reg;
            logic                   sq;
            logic                   accept;
            logic                   qual;

            assign sq     = sync_reg[SYNC_STAGES-1];
            assign accept = (sq != level_reg) && (cnt_reg == CNT_LAST);

            // qual marks the edge at which sync_level flips in a qualifying direction
            always_comb begin
                qual = 1'b0;
                case (EDGE_MODE)
                    0:       qual = accept &  sq;
                    1:       qual = accept & ~sq;
                    default: qual = accept;
                endcase
            end

            always_ff @(posedge outclk or negedge reset_n) begin
                if (!reset_n) begin
                    sync_reg  <= {SYNC_STAGES{RST_LVL}};
                    cnt_reg   <= '0;
                    level_reg <= RST_LVL;
                    pulse_reg <= 1'b0;
                    pend_reg  <= 1'b0;
                    ovr_reg   <= 1'b0;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], async_in[gi]};
                    if (sq == level_reg) begin
                        cnt_reg <= '0;
                    end else if (accept) begin
                        level_reg <= sq;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                    pulse_reg <= qual;
                    // a new event keeps pending high even when acked in the same cycle
                    pend_reg  <= qual | (pend_reg & ~evt_ack[gi]);
                    ovr_reg   <= (qual & pend_reg & ~evt_ack[gi]) | (ovr_reg & ~ovr_clr);
                end
            end

            assign sync_level[gi]  = level_reg;
            assign edge_pulse[gi]  = pulse_reg;
            assign evt_pending[gi] = pend_reg;
            assign evt_overrun[gi] = ovr_reg;
        end
    endgenerate

endmodule

// File: tb/tb_multi_channel_edge_sync.sv
// Randomized and directed bench for multi_channel_edge_sync: a default instance
// and a both-edge / FILTER_LEN=1 / 3-stage instance, checked against a history model.
module tb_multi_channel_edge_sync;

    localparam int MAXT = 8192;

    logic       outclk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] async_a = '0, ack_a = '0;
    logic       clr_a = 1'b0;
    logic [1:0] async_b = '0, ack_b = '0;
    logic       clr_b = 1'b0;
    logic [3:0] lvl_a, pls_a, pnd_a, ovr_a;
    logic [1:0] lvl_b, pls_b, pnd_b, ovr_b;

    int n_total = 0;
    int n_bad   = 0;

    always #5 outclk = ~outclk;

    multi_channel_edge_sync dut_a (
        .outclk(outclk), .reset_n(reset_n), .async_in(async_a), .evt_ack(ack_a),
        .ovr_clr(clr_a), .sync_level(lvl_a), .edge_pulse(pls_a),
        .evt_pending(pnd_a), .evt_overrun(ovr_a)
    );

    multi_channel_edge_sync #(
        .N_CH(2), .SYNC_STAGES(3), .FILTER_LEN(1), .EDGE_MODE(2), .RESET_LEVEL(0)
    ) dut_b (
        .outclk(outclk), .reset_n(reset_n), .async_in(async_b), .evt_ack(ack_b),
        .ovr_clr(clr_b), .sync_level(lvl_b), .edge_pulse(pls_b),
        .evt_pending(pnd_b), .evt_overrun(ovr_b)
    );

    // Model: inputs captured per edge since reset; level flips once the last
    // FILTER_LEN pre-edge synchronized samples all disagree with it.
    int         t_edge [2];
    bit         hist   [2][4][MAXT];
    logic [3:0] m_lvl [2], m_pls [2], m_pnd [2], m_ovr [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            t_edge[m] = 0;
            m_lvl[m] = '0; m_pls[m] = '0; m_pnd[m] = '0; m_ovr[m] = '0;
        end
    endtask

    task automatic model_step(input int m, input int nch, input int s, input int fl,
                              input int em, input logic [3:0] ain, input logic [3:0] ack,
                              input logic clr);
        int t;
        t = ++t_edge[m];
        if (t >= MAXT) begin
            $display("FAIL model_overflow got=%0d exp<%0d", t, MAXT);
            $fatal(1, "model history exhausted");
        end
        for (int ch = 0; ch < nch; ch++) begin
            bit flip, q, v, nl;
            int idx;
            hist[m][ch][t] = ain[ch];
            flip = 1'b1;
            for (int k = 0; k < fl; k++) begin
                idx = t - k - s;
                v = (idx >= 1) ? hist[m][ch][idx] : 1'b0;
                if (v == m_lvl[m][ch]) flip = 1'b0;
            end
            nl = flip ? ~m_lvl[m][ch] : m_lvl[m][ch];
            q  = flip && (em == 2 || (em == 0 && nl) || (em == 1 && !nl));
            m_ovr[m][ch] = (q && m_pnd[m][ch] && !ack[ch]) || (m_ovr[m][ch] && !clr);
            if (q)              m_pnd[m][ch] = 1'b1;
            else if (ack[ch])   m_pnd[m][ch] = 1'b0;
            m_pls[m][ch] = q;
            m_lvl[m][ch] = nl;
        end
    endtask

    task automatic compare_all();
        check("a_level",   {28'd0, lvl_a}, {28'd0, m_lvl[0]});
        check("a_pulse",   {28'd0, pls_a}, {28'd0, m_pls[0]});
        check("a_pending", {28'd0, pnd_a}, {28'd0, m_pnd[0]});
        check("a_overrun", {28'd0, ovr_a}, {28'd0, m_ovr[0]});
        check("b_level",   {30'd0, lvl_b}, {28'd0, m_lvl[1]});
        check("b_pulse",   {30'd0, pls_b}, {28'd0, m_pls[1]});
        check("b_pending", {30'd0, pnd_b}, {28'd0, m_pnd[1]});
        check("b_overrun", {30'd0, ovr_b}, {28'd0, m_ovr[1]});
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            model_step(0, 4, 2, 4, 0, async_a, ack_a, clr_a);
            model_step(1, 2, 3, 1, 2, {2'b00, async_b}, {2'b00, ack_b}, clr_b);
            @(posedge outclk);
            @(negedge outclk);
            compare_all();
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        async_a = '0; ack_a = '0; clr_a = 1'b0;
        async_b = '0; ack_b = '0; clr_b = 1'b0;
        repeat (2) @(negedge outclk);
        model_reset();
        compare_all();
        reset_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        check("rst_level", {28'd0, lvl_a}, 32'd0);
        check("rst_pend",  {28'd0, pnd_a}, 32'd0);
        tick(3);
        check("rst_nopulse", {28'd0, pls_a}, 32'd0);
        $display("txn reset: total=%0d bad=%0d", n_total, n_bad);

        // ch0 rising edge latency on the default instance
        async_a[0] = 1'b1;
        tick(5);
        check("lat_before", {31'd0, lvl_a[0]}, 32'd0);
        tick(1);
        check("lat_level", {31'd0, lvl_a[0]}, 32'd1);
        check("lat_pulse", {31'd0, pls_a[0]}, 32'd1);
        check("lat_pend",  {31'd0, pnd_a[0]}, 32'd1);
        tick(1);
        check("lat_pulse_end", {31'd0, pls_a[0]}, 32'd0);
        $display("txn latency: total=%0d bad=%0d", n_total, n_bad);

        // ch1 glitch of 3 cycles rejected, 4 cycles accepted
        async_a[1] = 1'b1; tick(3); async_a[1] = 1'b0; tick(8);
        check("glitch_level", {31'd0, lvl_a[1]}, 32'd0);
        check("glitch_pend",  {31'd0, pnd_a[1]}, 32'd0);
        async_a[1] = 1'b1; tick(4); async_a[1] = 1'b0; tick(2);
        check("accept4_pend", {31'd0, pnd_a[1]}, 32'd1);
        tick(6);
        $display("txn glitch: total=%0d bad=%0d", n_total, n_bad);

        // ch2 ack clears pending, then two events without ack overrun
        async_a[2] = 1'b1; tick(6); tick(10);
        ack_a[2] = 1'b1; tick(1); ack_a[2] = 1'b0;
        check("ack_clear", {31'd0, pnd_a[2]}, 32'd0);
        async_a[2] = 1'b0; tick(8); async_a[2] = 1'b1; tick(8);
        check("ovr_none", {31'd0, ovr_a[2]}, 32'd0);
        async_a[2] = 1'b0; tick(8); async_a[2] = 1'b1; tick(8);
        check("ovr_set", {31'd0, ovr_a[2]}, 32'd1);
        $display("txn handshake: total=%0d bad=%0d", n_total, n_bad);

        // ch3 ack coinciding with a new edge; ovr_clr coinciding with overrun
        async_a[3] = 1'b1; tick(8); async_a[3] = 1'b0; tick(8);
        async_a[3] = 1'b1; tick(5); ack_a[3] = 1'b1; tick(1); ack_a[3] = 1'b0;
        check("simul_pend", {31'd0, pnd_a[3]}, 32'd1);
        check("simul_ovr",  {31'd0, ovr_a[3]}, 32'd0);
        async_a[3] = 1'b0; tick(8);
        async_a[3] = 1'b1; tick(5); clr_a = 1'b1; tick(1); clr_a = 1'b0;
        check("clr_vs_set", {31'd0, ovr_a[3]}, 32'd1);
        clr_a = 1'b1; tick(1); clr_a = 1'b0;
        check("clr_done", {28'd0, ovr_a}, 32'd0);
        $display("txn simultaneous: total=%0d bad=%0d", n_total, n_bad);

        // both-edge instance: latency 4 edges, pulse on each direction
        async_b[0] = 1'b1; tick(3);
        check("b_rise_before", {31'd0, lvl_b[0]}, 32'd0);
        tick(1);
        check("b_rise_pulse", {31'd0, pls_b[0]}, 32'd1);
        async_b[0] = 1'b0; tick(4);
        check("b_fall_pulse", {31'd0, pls_b[0]}, 32'd1);
        check("b_fall_level", {31'd0, lvl_b[0]}, 32'd0);
        $display("txn both_edges: total=%0d bad=%0d", n_total, n_bad);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            for (int ch = 0; ch < 4; ch++) begin
                if ($urandom_range(0, 4) == 0) async_a[ch] = ~async_a[ch];
                ack_a[ch] = ($urandom_range(0, 7) == 0);
            end
            for (int ch = 0; ch < 2; ch++) begin
                if ($urandom_range(0, 3) == 0) async_b[ch] = ~async_b[ch];
                ack_b[ch] = ($urandom_range(0, 5) == 0);
            end
            clr_a = ($urandom_range(0, 15) == 0);
            clr_b = ($urandom_range(0, 15) == 0);
            tick(1);
        end
        ack_a = '0; ack_b = '0; clr_a = 1'b0; clr_b = 1'b0;
        $display("txn random: total=%0d bad=%0d", n_total, n_bad);

        // asynchronous reset mid-count with events pending
        async_a = 4'hF; async_b = 2'b11; tick(2);
        async_a = 4'h0; tick(4);
        #2 reset_n = 1'b0;
        #1;
        check("arst_level", {28'd0, lvl_a}, 32'd0);
        check("arst_pulse", {28'd0, pls_a}, 32'd0);
        check("arst_pend",  {28'd0, pnd_a}, 32'd0);
        check("arst_ovr",   {28'd0, ovr_a}, 32'd0);
        check("arst_b",     {24'd0, lvl_b, pls_b, pnd_b, ovr_b}, 32'd0);
        do_reset();
        tick(8);
        check("rel_nopulse", {28'd0, pnd_a}, 32'd0);
        $display("txn async_reset: total=%0d bad=%0d", n_total, n_bad);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
